// File: rtl/act_out_packer_if.sv
// Write-side bus from the activation packer to feature-map memory.
// The packer drives a word, its address and a request; memory answers with ack.
interface act_out_packer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 12
);
   logic [DATA_WIDTH-1:0] wr_data;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic                  wr_req;
   logic                  wr_ack;

   modport master (
      output wr_data,
      output wr_addr,
      output wr_req,
      input  wr_ack
   );

   modport slave (
      input  wr_data,
      input  wr_addr,
      input  wr_req,
      output wr_ack
   );
endinterface

// File: rtl/act_out_packer.sv
// Consumer end of the activation output stream. Each activation is requantized
// to a signed lane, PACK lanes are gathered into one memory word, words queue in
// a small FIFO, and a two-state writer drains them to feature-map memory over a
// req/ack handshake with a per-frame wrapping word address.
module act_out_packer #(
   parameter int IN_WIDTH    = 14,
   parameter int FRAC_BITS   = 7,
   parameter int OUT_WIDTH   = 8,
   parameter int SHIFT       = 3,
   parameter int PACK        = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int ADDR_WIDTH  = 12,
   parameter int FRAME_WORDS = 196
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic signed [IN_WIDTH-1:0]    in_data,
   input  logic                          in_valid,
   input  logic                          in_last,
   input  logic                          frame_start,
   act_out_packer_if.master              mem,
   output logic                          frame_done,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

   localparam int WORD_W = PACK * OUT_WIDTH;
   localparam int LANE_W = (PACK > 1) ? $clog2(PACK) : 1;
   localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1;

   localparam logic signed [IN_WIDTH:0] ROUND   = (IN_WIDTH+1)'(2 ** (SHIFT - 1));
   localparam logic signed [IN_WIDTH:0] SAT_MAX = (IN_WIDTH+1)'(2 ** (OUT_WIDTH - 1) - 1);
   localparam logic signed [IN_WIDTH:0] SAT_MIN = (IN_WIDTH+1)'(-(2 ** (OUT_WIDTH - 1)));
   localparam logic [ADDR_WIDTH-1:0]    LAST_ADDR = ADDR_WIDTH'(FRAME_WORDS - 1);

   // The rounding constant needs at least one shifted-out bit, and the input
   // must keep at least one integer bit for the fixed-point format to make sense.
   if (SHIFT < 1 || FRAC_BITS >= IN_WIDTH) begin : g_bad_params
      $error("act_out_packer: SHIFT must be >= 1 and FRAC_BITS < IN_WIDTH");
   end

   typedef enum logic {
      IDLE,
      REQ
   } state_t;

   state_t                   state;
   logic signed [IN_WIDTH:0] biased;
   logic signed [IN_WIDTH:0] shifted;
   logic [OUT_WIDTH-1:0]     sat_q;
   logic                     r_valid;
   logic                     r_last;
   logic [OUT_WIDTH-1:0]     r_q;
   logic [LANE_W-1:0]        lane_cnt;
   logic [WORD_W-1:0]        pack_reg;
   logic [WORD_W-1:0]        new_word;
   logic                     push;
   logic                     push_ok;
   logic                     pop;
   logic                     full;
   logic [WORD_W-1:0]        fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr;
   logic [PTR_W-1:0]         rd_ptr;
   logic [LVL_W-1:0]         count;
   logic [ADDR_WIDTH-1:0]    addr;
   logic [ADDR_WIDTH-1:0]    issue_addr;

   function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
      return (a == LAST_ADDR) ? '0 : a + 1'b1;
   endfunction

   // Round half up by adding half an output LSB before the arithmetic shift,
   // then clamp into the signed lane range. One extra bit keeps the add exact.
   always_comb begin
      biased  = {in_data[IN_WIDTH-1], in_data} + ROUND;
      shifted = biased >>> SHIFT;
      if (shifted > SAT_MAX) begin
         sat_q = SAT_MAX[OUT_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
         sat_q = SAT_MIN[OUT_WIDTH-1:0];
      end else begin
         sat_q = shifted[OUT_WIDTH-1:0];
      end
   end

   // Stage R: register the requantized lane together with its row-end flag.
   // A frame_start on the same edge still captures a new sample here; it becomes
   // lane 0 of the new frame, while the entry leaving this stage is discarded below.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_last  <= 1'b0;
         r_q     <= '0;
      end else begin
         r_valid <= in_valid;
         if (in_valid) begin
            r_q    <= sat_q;
            r_last <= in_last;
         end
      end
   end

   // The word as it looks with the current lane dropped into place; lanes not
   // yet filled are still zero in the pack register.
   always_comb begin
      new_word = pack_reg;
      new_word[lane_cnt*OUT_WIDTH +: OUT_WIDTH] = r_q;
   end

   assign push    = r_valid && !frame_start && ((lane_cnt == LANE_W'(PACK - 1)) || r_last);
   assign pop     = (state == REQ) && mem.wr_ack;
   assign full    = (count == LVL_W'(FIFO_DEPTH));
   assign push_ok = push && (!full || pop);

   // Stage P: accumulate lanes; a completed or row-terminated word leaves for the
   // FIFO on this edge and the accumulator restarts at lane 0.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_cnt <= '0;
         pack_reg <= '0;
      end else if (frame_start) begin
         lane_cnt <= '0;
         pack_reg <= '0;
      end else if (r_valid) begin
         if (push) begin
            lane_cnt <= '0;
            pack_reg <= '0;
         end else begin
            lane_cnt <= lane_cnt + 1'b1;
            pack_reg <= new_word;
         end
      end
   end

   // Word storage has no reset; emptiness is tracked purely by the pointers.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= new_word;
      end
   end

   // FIFO bookkeeping. A push into a full FIFO is still taken when the head is
   // popped on the same edge, because the head word already sits in wr_data.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + LVL_W'(push_ok) - LVL_W'(pop);
      end
   end

   // Sticky drop flag; a new frame gives the consumer a clean slate.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow <= 1'b0;
      end else if (frame_start) begin
         overflow <= 1'b0;
      end else if (push && !push_ok) begin
         overflow <= 1'b1;
      end
   end

   // A frame_start restarts numbering with whatever word is issued next; a word
   // already on the bus keeps the address it was issued with.
   assign issue_addr = frame_start ? '0 : addr;

   // Writer: issue the FIFO head, hold it until ack, then either chain straight
   // into the next word (no idle cycle) or fall back to IDLE. When only one word
   // remains and a new one arrives on the ack edge, it is taken from the packer
   // directly since it has not landed in storage yet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mem.wr_req  <= 1'b0;
         mem.wr_data <= '0;
         mem.wr_addr <= '0;
         addr        <= '0;
         frame_done  <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (frame_start) begin
            addr <= '0;
         end
         case (state)
            IDLE: begin
               if (count != '0) begin
                  mem.wr_data <= fifo_mem[rd_ptr];
                  mem.wr_addr <= issue_addr;
                  addr        <= wrap_inc(issue_addr);
                  mem.wr_req  <= 1'b1;
                  state       <= REQ;
               end
            end
            REQ: begin
               if (mem.wr_ack) begin
                  if (mem.wr_addr == LAST_ADDR) begin
                     frame_done <= 1'b1;
                  end
                  if (count > LVL_W'(1)) begin
                     mem.wr_data <= fifo_mem[rd_ptr + 1'b1];
                     mem.wr_addr <= issue_addr;
                     addr        <= wrap_inc(issue_addr);
                  end else if (push_ok) begin
                     mem.wr_data <= new_word;
                     mem.wr_addr <= issue_addr;
                     addr        <= wrap_inc(issue_addr);
                  end else begin
                     mem.wr_req <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: begin
               state      <= IDLE;
               mem.wr_req <= 1'b0;
            end
         endcase
      end
   end

   assign fifo_level = count;

endmodule

// File: tb/tb_act_out_packer.sv
// Bench for act_out_packer: a reference model turns each driven activation into
// expected memory words, and a monitor pops and compares them on every write.
module tb_act_out_packer;

   localparam int IN_WIDTH    = 14;
   localparam int OUT_WIDTH   = 8;
   localparam int SHIFT       = 3;
   localparam int PACK        = 4;
   localparam int FIFO_DEPTH  = 8;
   localparam int ADDR_WIDTH  = 12;
   localparam int FRAME_WORDS = 196;
   localparam int WORD_W      = PACK * OUT_WIDTH;
   localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

   logic                       clk = 1'b0;
   logic                       rst = 1'b1;
   logic signed [IN_WIDTH-1:0] in_data = '0;
   logic                       in_valid = 1'b0;
   logic                       in_last = 1'b0;
   logic                       frame_start = 1'b0;
   logic                       frame_done;
   logic                       overflow;
   logic [LVL_W-1:0]           fifo_level;

   act_out_packer_if #(.DATA_WIDTH(WORD_W), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   act_out_packer #(
      .IN_WIDTH(IN_WIDTH), .FRAC_BITS(7), .OUT_WIDTH(OUT_WIDTH), .SHIFT(SHIFT),
      .PACK(PACK), .FIFO_DEPTH(FIFO_DEPTH), .ADDR_WIDTH(ADDR_WIDTH),
      .FRAME_WORDS(FRAME_WORDS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_last(in_last),
      .frame_start(frame_start),
      .mem(bus.master),
      .frame_done(frame_done),
      .overflow(overflow),
      .fifo_level(fifo_level)
   );

   always #5 clk = ~clk;

   int                checks_total   = 0;
   int                checks_passed  = 0;
   int                model_lanes[$];
   logic [WORD_W-1:0] exp_words[$];
   int                model_occ      = 0;
   bit                model_blocked  = 1'b0;
   bit                model_overflow = 1'b0;
   int                exp_addr       = 0;
   int                done_seen      = 0;

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      checks_total++;
      if (actual === expected) begin
         checks_passed++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   // Requantization from first principles: floor((x + 2^(SHIFT-1)) / 2^SHIFT),
   // clamped to the signed output range.
   function automatic int requant(input int x);
      int v;
      int d;
      int q;
      d = 1 << SHIFT;
      v = x + (1 << (SHIFT - 1));
      if (v >= 0) q = v / d;
      else        q = -((-v + d - 1) / d);
      if (q > (1 << (OUT_WIDTH - 1)) - 1) q = (1 << (OUT_WIDTH - 1)) - 1;
      if (q < -(1 << (OUT_WIDTH - 1)))    q = -(1 << (OUT_WIDTH - 1));
      return q;
   endfunction

   // A word closes after PACK lanes or at a row end; when memory is stalled,
   // anything beyond FIFO_DEPTH outstanding words is lost.
   function automatic void modelSample(input int x, input bit last);
      longint w;
      model_lanes.push_back(requant(x));
      if (model_lanes.size() == PACK || last) begin
         w = 0;
         foreach (model_lanes[i]) begin
            w += longint'(model_lanes[i] & ((1 << OUT_WIDTH) - 1)) << (OUT_WIDTH * i);
         end
         if (model_blocked && model_occ >= FIFO_DEPTH) begin
            model_overflow = 1'b1;
         end else begin
            exp_words.push_back(WORD_W'(w));
            model_occ++;
         end
         model_lanes.delete();
      end
   endfunction

   function automatic void modelFrameStart();
      model_lanes.delete();
      exp_addr       = 0;
      model_overflow = 1'b0;
   endfunction

   // Drive one sample for one cycle, optionally together with frame_start.
   task automatic applyStimulus(input int x, input bit last, input bit fs = 1'b0);
      if (fs) modelFrameStart();
      in_data     = IN_WIDTH'(x);
      in_valid    = 1'b1;
      in_last     = last;
      frame_start = fs;
      modelSample(x, last);
      @(posedge clk);
      #1;
      in_valid    = 1'b0;
      in_last     = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic pulseFrameStart();
      modelFrameStart();
      frame_start = 1'b1;
      @(posedge clk);
      #1;
      frame_start = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic int randData();
      return int'($urandom_range(0, (1 << IN_WIDTH) - 1)) - (1 << (IN_WIDTH - 1));
   endfunction

   task automatic waitDrain(input int budget);
      int cycles;
      bit done;
      cycles = 0;
      done   = 1'b0;
      repeat (3) @(posedge clk);
      while (!done && cycles < budget) begin
         @(negedge clk);
         cycles++;
         if (exp_words.size() == 0 && !bus.wr_req && fifo_level == '0) done = 1'b1;
      end
      if (!done) checkOutput("drain_timeout_words_left", 64'(exp_words.size()), 0);
      @(posedge clk);
      #1;
   endtask

   // Monitor: compare every accepted write against the scoreboard, check that
   // a pending request holds still, and check the end-of-frame pulse.
   logic              pend = 1'b0;
   logic [WORD_W-1:0] pend_data;
   logic [ADDR_WIDTH-1:0] pend_addr;
   bit                exp_done = 1'b0;
   logic [WORD_W-1:0] mon_word;

   always @(negedge clk) begin
      if (!rst) begin
         if (frame_done) done_seen++;
         if (exp_done || frame_done) checkOutput("frame_done", 64'(frame_done), 64'(exp_done));
         exp_done = 1'b0;
         if (pend) begin
            checkOutput("req_hold", {bus.wr_req, bus.wr_data, bus.wr_addr},
                        {1'b1, pend_data, pend_addr});
         end
         pend = 1'b0;
         if (bus.wr_req && bus.wr_ack) begin
            if (exp_words.size() == 0) begin
               checkOutput("unexpected_write", 64'(bus.wr_data), 0);
            end else begin
               mon_word = exp_words.pop_front();
               checkOutput("wr_data", 64'(bus.wr_data), 64'(mon_word));
               checkOutput("wr_addr", 64'(bus.wr_addr), 64'(exp_addr));
            end
            if (exp_addr == FRAME_WORDS - 1) begin
               exp_done = 1'b1;
               exp_addr = 0;
            end else begin
               exp_addr++;
            end
            model_occ--;
         end else if (bus.wr_req) begin
            pend      = 1'b1;
            pend_data = bus.wr_data;
            pend_addr = bus.wr_addr;
         end
      end
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, passed %0d of %0d", checks_passed, checks_total);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      bus.wr_ack = 1'b0;

      // Reset state
      #12;
      checkOutput("rst_wr_req", 64'(bus.wr_req), 0);
      checkOutput("rst_wr_data", 64'(bus.wr_data), 0);
      checkOutput("rst_wr_addr", 64'(bus.wr_addr), 0);
      checkOutput("rst_frame_done", 64'(frame_done), 0);
      checkOutput("rst_overflow", 64'(overflow), 0);
      checkOutput("rst_fifo_level", 64'(fifo_level), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.wr_ack = 1'b1;

      // Rounding and saturation at both ends
      applyStimulus(384, 1'b0);
      applyStimulus(12, 1'b0);
      applyStimulus(11, 1'b0);
      applyStimulus(8191, 1'b0);
      applyStimulus(-1, 1'b0);
      applyStimulus(-8192, 1'b1);
      waitDrain(50);

      // Full word with minimum latency
      applyStimulus(8, 1'b0);
      applyStimulus(16, 1'b0);
      applyStimulus(24, 1'b0);
      applyStimulus(32, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("latency_req_early", 64'(bus.wr_req), 0);
      @(posedge clk);
      #1;
      checkOutput("latency_req", 64'(bus.wr_req), 1);
      checkOutput("pack_word", 64'(bus.wr_data), 64'h04030201);
      waitDrain(50);

      // Row end flushes a partial word
      applyStimulus(40, 1'b0);
      applyStimulus(48, 1'b1);
      waitDrain(50);

      // Stalled memory: FIFO fills, extra words are dropped
      pulseFrameStart();
      bus.wr_ack    = 1'b0;
      model_blocked = 1'b1;
      for (int i = 0; i < 40; i++) applyStimulus(randData(), 1'b0);
      idleCycles(6);
      checkOutput("fifo_level_full", 64'(fifo_level), 64'(model_occ));
      checkOutput("overflow_set", 64'(overflow), 64'(model_overflow));
      model_blocked = 1'b0;
      bus.wr_ack    = 1'b1;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
         @(negedge clk);
         checkOutput("no_bubble", 64'(bus.wr_req), 1);
      end
      @(negedge clk);
      checkOutput("req_low_after_drain", 64'(bus.wr_req), 0);
      @(posedge clk);
      #1;
      waitDrain(50);

      // frame_start in the middle of a word, then a sample coinciding with it
      for (int i = 0; i < 3; i++) applyStimulus(randData(), 1'b0);
      pulseFrameStart();
      for (int i = 0; i < 4; i++) applyStimulus(randData(), 1'b0);
      waitDrain(50);
      checkOutput("overflow_cleared", 64'(overflow), 64'(model_overflow));
      for (int i = 0; i < 2; i++) applyStimulus(randData(), 1'b0);
      applyStimulus(randData(), 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) applyStimulus(randData(), 1'b0);
      waitDrain(50);

      // Address wrap across a full frame
      pulseFrameStart();
      done_seen = 0;
      for (int i = 0; i < (FRAME_WORDS + 1) * PACK; i++) applyStimulus(randData(), 1'b0);
      waitDrain(200);
      checkOutput("frame_done_count", 64'(done_seen), 1);

      // Random traffic with a randomly stalling memory
      for (int i = 0; i < 400; i++) begin
         bus.wr_ack = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 1) begin
            applyStimulus(randData(), $urandom_range(0, 7) == 0);
         end else begin
            idleCycles(1);
         end
      end
      applyStimulus(randData(), 1'b1);
      bus.wr_ack = 1'b1;
      waitDrain(200);
      checkOutput("random_overflow", 64'(overflow), 64'(model_overflow));

      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

endmodule

// File: doc/act_out_packer.md
Name: act_out_packer

Overview:
- Consumer-side end of the activation segment output stream (data + single-cycle valid, no backpressure).
- Requantizes each 14-bit Q6.7 activation to signed 8-bit with round-half-up and saturation.
- Packs PACK results per memory word and buffers words in a small FIFO.
- Drains words to feature-map memory through a req/ack write handshake with a wrapping address counter.

Parameters:
- IN_WIDTH, 14, input activation width (signed, FRAC_BITS fractional bits)
- FRAC_BITS, 7, input fractional bits (informational; scaling set by SHIFT)
- OUT_WIDTH, 8, requantized lane width (signed)
- SHIFT, 3, arithmetic right shift applied in requantization (must be >= 1)
- PACK, 4, lanes per memory word; word width = PACK*OUT_WIDTH
- FIFO_DEPTH, 8, word FIFO depth (power of two)
- ADDR_WIDTH, 12, memory word address width
- FRAME_WORDS, 196, words per frame; address wraps after FRAME_WORDS-1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_data  in  IN_WIDTH  signed activation from activation segment
- in_valid  in  1  in_data qualifier; any number of back-to-back cycles
- in_last  in  1  with in_valid: last element of row; flushes a partial word
- frame_start  in  1  one-cycle pulse: restarts frame
- wr_data  out  PACK*OUT_WIDTH  packed word, lane 0 in LSBs
- wr_addr  out  ADDR_WIDTH  word address
- wr_req  out  1  write request
- wr_ack  in  1  memory accepts current word
- frame_done  out  1  one-cycle pulse on ack of word FRAME_WORDS-1
- overflow  out  1  sticky: a word was dropped because FIFO was full
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (async, rst=1): all outputs 0; lane counter 0; pack register 0; FIFO empty; FSM IDLE; address 0.
- Stage R (edge 1 after in_valid):
  - q = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed in IN_WIDTH+1 bits.
  - Saturate q to [-128, 127] (OUT_WIDTH=8).
  - in_last is delayed alongside q.
- Stage P (edge 2):
  - q is written into lane[lane_cnt]; lane_cnt increments.
  - If lane_cnt==PACK-1 or the delayed in_last=1, the assembled word (pack register + new lane; unfilled lanes 0) is pushed to the FIFO on this same edge.
  - lane_cnt and the pack register then clear.
- FIFO push rule:
  - Push is accepted if not full, or if a pop occurs on the same edge.
  - Otherwise the word is discarded and overflow is set.
- Write FSM, two states:
  - IDLE: when FIFO non-empty, load wr_data = head and wr_addr = addr; assert wr_req; go to REQ.
  - REQ: wr_req, wr_data and wr_addr are held stable until wr_ack=1 is sampled.
  - On ack: pop; addr <= (addr==FRAME_WORDS-1) ? 0 : addr+1. If addr was FRAME_WORDS-1, pulse frame_done.
  - After ack, if the FIFO still holds another word (level>1, or a push on the same edge), stay in REQ and present the next word on the following cycle with no bubble. Otherwise drop wr_req and return to IDLE.
  - wr_ack while in IDLE is ignored.
- Minimum latency: in_valid completing a word at cycle t gives wr_req high starting at cycle t+3.
- frame_start (synchronous):
  - Clears lane_cnt, the pack register (partial word discarded), the in-flight Stage R entry, and overflow.
  - Sets addr to 0 for the next word issued.
  - FIFO contents and any outstanding request are unaffected; the outstanding request completes with its original address.
- frame_start coinciding with in_valid: the new sample is kept as lane 0 of the new frame.
- Reset mid-transaction: wr_req drops immediately. The memory must treat the dropped request as not written.

Test Plan:
- Requant/rounding: in_data = 384, 12, 11, 8191, -1 (14'h3FFF), -8192 → lanes 48, 2, 1, 127, 0, -128 (saturation both ends).
- Packing: 4 back-to-back valids of values giving 1, 2, 3, 4 with wr_ack held high → wr_data=32'h04030201, wr_addr=0, wr_req rises 3 cycles after the 4th valid.
- Partial flush: 2 valids (results 5, 6), second with in_last=1 → wr_data=32'h00000605; the next word starts at lane 0.
- Backpressure/overflow: wr_ack held 0, 40 valids (10 words) → fifo_level saturates at 8 and overflow=1. Release ack → exactly 8 words at addresses 0..7, back-to-back with no bubble.
- Frame wrap: FRAME_WORDS=196; stream 197 words with ack always 1 → frame_done pulses once, on ack of addr 195; word 197 is written to addr 0.
- frame_start mid-word: 3 valids, frame_start, then 4 valids → first pushed word contains only the last 4 values, at addr 0; overflow cleared.
